// File: rtl/regfile_mp_pkg.sv
// cpuDefine: shared core element types plus register-file defaults and state encoding.
// Imported by regfile_mp and regfile_scoreboard.
package cpuDefine;

    localparam int RF_NUM_RD = 4;
    localparam int RF_NUM_WR = 2;
    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 5;

    typedef logic [31:0] DType;
    typedef DType Gr;

    typedef logic [RF_ADDR_W-1:0] RfIdx;

    typedef enum logic [0:0] {
        RF_CLEAR = 1'b0,
        RF_RUN   = 1'b1
    } RfState;

    function automatic int rfDepth(input int addrW);
        return 1 << addrW;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: one busy bit per register, tracking destinations that are issued but not yet written.
// Flush beats issue, and issue beats write-clear on the same index.
module regfile_scoreboard
    import cpuDefine::*;
#(
    parameter int NUM_RD = RF_NUM_RD,
    parameter int NUM_WR = RF_NUM_WR,
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     run_i,
    input  logic [NUM_WR-1:0]        wr_en_i,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr_i,
    input  logic [NUM_WR-1:0]        issue_en_i,
    input  logic [NUM_WR*ADDR_W-1:0] issue_addr_i,
    input  logic                     flush_i,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
    output logic [NUM_RD-1:0]        busy_o
);

    localparam int DEPTH = rfDepth(ADDR_W);

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    // Writes are ignored outside RUN, so they must not retire a pending producer either.
    always_comb begin
        busy_d = busy_q;
        if (flush_i) begin
            busy_d = '0;
        end else begin
            for (int w = 0; w < NUM_WR; w++) begin
                if (run_i && wr_en_i[w]) begin
                    busy_d[wr_addr_i[w*ADDR_W +: ADDR_W]] = 1'b0;
                end
            end
            for (int w = 0; w < NUM_WR; w++) begin
                if (issue_en_i[w]) begin
                    busy_d[issue_addr_i[w*ADDR_W +: ADDR_W]] = 1'b1;
                end
            end
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_busy
        logic [ADDR_W-1:0] rdIdx;
        logic              wrHit;

        assign rdIdx = rd_addr_i[p*ADDR_W +: ADDR_W];

        always_comb begin
            wrHit = 1'b0;
            for (int w = 0; w < NUM_WR; w++) begin
                if (wr_en_i[w] && (wr_addr_i[w*ADDR_W +: ADDR_W] == rdIdx)) begin
                    wrHit = 1'b1;
                end
            end
        end

        assign busy_o[p] = run_i && (rdIdx != '0) && busy_q[rdIdx] && !wrHit;
    end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with same-cycle write bypass, r0 tied to zero and a post-reset clearing pass.
// Define REGFILE_SCOREBOARD_EN to add the busy-bit scoreboard (issue/flush/busy ports).
module regfile_mp
    import cpuDefine::*;
#(
    parameter int NUM_RD = RF_NUM_RD,
    parameter int NUM_WR = RF_NUM_WR,
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
    output logic [NUM_RD*DATA_W-1:0] rd_data_o,
    input  logic [NUM_WR-1:0]        wr_en_i,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr_i,
    input  logic [NUM_WR*DATA_W-1:0] wr_data_i,
    output logic                     init_done_o
`ifdef REGFILE_SCOREBOARD_EN
    ,
    input  logic [NUM_WR-1:0]        issue_en_i,
    input  logic [NUM_WR*ADDR_W-1:0] issue_addr_i,
    input  logic                     flush_i,
    output logic [NUM_RD-1:0]        busy_o
`endif
);

    localparam int              DEPTH    = rfDepth(ADDR_W);
    localparam logic [0:0]      ST_CLEAR = RF_CLEAR;
    localparam logic [0:0]      ST_RUN   = RF_RUN;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    logic [0:0]        state_q;
    logic [0:0]        state_d;
    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] cnt_d;
    logic              init_done_q;
    logic              init_done_d;
    logic              run;

    // Entry 0 has no storage; reads of r0 are forced to zero instead.
    logic [DATA_W-1:0] mem [1:DEPTH-1];

    assign run         = (state_q == ST_RUN);
    assign init_done_o = init_done_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        init_done_d = init_done_q;
        if (state_q == ST_CLEAR) begin
            cnt_d = cnt_q + ADDR_W'(1);
            if (cnt_q == LAST_IDX) begin
                state_d     = ST_RUN;
                init_done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= ST_CLEAR;
            cnt_q       <= ADDR_W'(1);
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_done_q <= init_done_d;
        end
    end

    // Later loop iterations override earlier ones, so the youngest port wins a same-index collision.
    always_ff @(posedge aclk) begin
        if (!run) begin
            mem[cnt_q] <= '0;
        end else begin
            for (int w = 0; w < NUM_WR; w++) begin
                if (wr_en_i[w] && (wr_addr_i[w*ADDR_W +: ADDR_W] != '0)) begin
                    mem[wr_addr_i[w*ADDR_W +: ADDR_W]] <= wr_data_i[w*DATA_W +: DATA_W];
                end
            end
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] rdIdx;
        logic [DATA_W-1:0] rdVal;

        assign rdIdx = rd_addr_i[p*ADDR_W +: ADDR_W];

        always_comb begin
            rdVal = '0;
            if (run && (rdIdx != '0)) begin
                rdVal = mem[rdIdx];
                for (int w = 0; w < NUM_WR; w++) begin
                    if (wr_en_i[w] && (wr_addr_i[w*ADDR_W +: ADDR_W] == rdIdx)) begin
                        rdVal = wr_data_i[w*DATA_W +: DATA_W];
                    end
                end
            end
        end

        assign rd_data_o[p*DATA_W +: DATA_W] = rdVal;
    end

`ifdef REGFILE_SCOREBOARD_EN
    regfile_scoreboard #(
        .NUM_RD (NUM_RD),
        .NUM_WR (NUM_WR),
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .run_i        (run),
        .wr_en_i      (wr_en_i),
        .wr_addr_i    (wr_addr_i),
        .issue_en_i   (issue_en_i),
        .issue_addr_i (issue_addr_i),
        .flush_i      (flush_i),
        .rd_addr_i    (rd_addr_i),
        .busy_o       (busy_o)
    );
`endif

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: checks regfile_mp against an array-based reference model of the register file.
// Scoreboard checks are included when REGFILE_SCOREBOARD_EN is defined.
module tb_regfile_mp;

    localparam int NRD          = 4;
    localparam int NWR          = 2;
    localparam int DW           = 32;
    localparam int AW           = 5;
    localparam int DEPTH        = 32;
    localparam int CLEAR_CYCLES = 31;

    logic              aclk = 1'b0;
    logic              aresetn;
    logic [NRD*AW-1:0] rdAddr;
    logic [NRD*DW-1:0] rdData;
    logic [NWR-1:0]    wrEn;
    logic [NWR*AW-1:0] wrAddr;
    logic [NWR*DW-1:0] wrData;
    logic              initDone;
`ifdef REGFILE_SCOREBOARD_EN
    logic [NWR-1:0]    issueEn;
    logic [NWR*AW-1:0] issueAddr;
    logic              flush;
    logic [NRD-1:0]    busy;
`endif

    int assertCount = 0;
    int failCount   = 0;

    // Reference model state: register contents, whether clearing has finished, and edges seen since reset release.
    logic [DW-1:0] refMem [DEPTH];
    bit            refRun;
    int            clearEdges;

    regfile_mp #(
        .NUM_RD (NRD),
        .NUM_WR (NWR),
        .DATA_W (DW),
        .ADDR_W (AW)
    ) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .rd_addr_i    (rdAddr),
        .rd_data_o    (rdData),
        .wr_en_i      (wrEn),
        .wr_addr_i    (wrAddr),
        .wr_data_i    (wrData),
        .init_done_o  (initDone)
`ifdef REGFILE_SCOREBOARD_EN
        ,
        .issue_en_i   (issueEn),
        .issue_addr_i (issueAddr),
        .flush_i      (flush),
        .busy_o       (busy)
`endif
    );

    always #5 aclk = ~aclk;

    task automatic setRead(input int p, input logic [AW-1:0] a);
        rdAddr[p*AW +: AW] = a;
    endtask

    task automatic setWrite(input int w, input logic en, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wrEn[w]            = en;
        wrAddr[w*AW +: AW] = a;
        wrData[w*DW +: DW] = d;
    endtask

    task automatic idleInputs();
        wrEn   = '0;
        wrAddr = '0;
        wrData = '0;
        rdAddr = '0;
`ifdef REGFILE_SCOREBOARD_EN
        issueEn   = '0;
        issueAddr = '0;
        flush     = 1'b0;
`endif
    endtask

    // Value a reader should see right now: zero for r0 or while clearing, else youngest matching write, else stored.
    function automatic logic [DW-1:0] modelRead(input logic [AW-1:0] a);
        logic [DW-1:0] v;
        if (!refRun || a == 0) return '0;
        v = refMem[a];
        for (int w = 0; w < NWR; w++)
            if (wrEn[w] && wrAddr[w*AW +: AW] == a) v = wrData[w*DW +: DW];
        return v;
    endfunction

    // One rising edge; the model is updated with the inputs that were present at that edge.
    task automatic tick();
        @(posedge aclk);
        if (refRun) begin
            for (int w = 0; w < NWR; w++)
                if (wrEn[w] && wrAddr[w*AW +: AW] != 0) refMem[wrAddr[w*AW +: AW]] = wrData[w*DW +: DW];
        end else if (aresetn) begin
            clearEdges++;
            if (clearEdges == CLEAR_CYCLES) begin
                refRun = 1'b1;
                for (int i = 0; i < DEPTH; i++) refMem[i] = '0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        int rise;
        idleInputs();
        aresetn    = 1'b0;
        refRun     = 1'b0;
        clearEdges = 0;
        for (int i = 0; i < DEPTH; i++) refMem[i] = 32'hBAD0_0000 + i;
        @(posedge aclk);
        #1;
        assertCount++;
        if (initDone !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL reset_init_done: got %b expected 0", initDone);
        end
        assertCount++;
        if (rdData !== '0) begin
            failCount++;
            $display("[TB] FAIL reset_rd_zero: got %h expected 0", rdData);
        end
        aresetn = 1'b1;
        rise = -1;
        for (int c = 1; c <= 40 && rise < 0; c++) begin
            if (c == 3) begin
                setWrite(0, 1'b1, 5'd5, 32'h0000_DEAD);
                setRead(0, 5'd5);
                #1;
                assertCount++;
                if (rdData[0 +: DW] !== 32'h0) begin
                    failCount++;
                    $display("[TB] FAIL clear_no_bypass: got %h expected 0", rdData[0 +: DW]);
                end
            end
            tick();
            setWrite(0, 1'b0, 5'd0, 32'h0);
            assertCount++;
            if (initDone !== refRun) begin
                failCount++;
                $display("[TB] FAIL clear_init_done cycle %0d: got %b expected %b", c, initDone, refRun);
            end
            if (initDone === 1'b1) rise = c;
        end
        assertCount++;
        if (rise != CLEAR_CYCLES) begin
            failCount++;
            $display("[TB] FAIL init_done_rise_cycle: got %0d expected %0d", rise, CLEAR_CYCLES);
        end
        for (int base = 1; base < DEPTH; base += NRD) begin
            for (int p = 0; p < NRD; p++) setRead(p, AW'(((base + p - 1) % (DEPTH - 1)) + 1));
            #1;
            for (int p = 0; p < NRD; p++) begin
                assertCount++;
                if (rdData[p*DW +: DW] !== 32'h0) begin
                    failCount++;
                    $display("[TB] FAIL cleared_entry r%0d: got %h expected 0", rdAddr[p*AW +: AW], rdData[p*DW +: DW]);
                end
            end
        end
    endtask

    task automatic test_same_index_write();
        idleInputs();
        setWrite(0, 1'b1, 5'd7, 32'h11);
        setWrite(1, 1'b1, 5'd7, 32'h22);
        setRead(0, 5'd7);
        #1;
        assertCount++;
        if (rdData[0 +: DW] !== modelRead(5'd7) || rdData[0 +: DW] !== 32'h22) begin
            failCount++;
            $display("[TB] FAIL same_index_bypass: got %h expected 00000022", rdData[0 +: DW]);
        end
        tick();
        wrEn = '0;
        #1;
        assertCount++;
        if (rdData[0 +: DW] !== modelRead(5'd7) || rdData[0 +: DW] !== 32'h22) begin
            failCount++;
            $display("[TB] FAIL same_index_stored: got %h expected 00000022", rdData[0 +: DW]);
        end
    endtask

    task automatic test_r0_write();
        idleInputs();
        setWrite(1, 1'b1, 5'd0, 32'hFFFF_FFFF);
        for (int cyc = 0; cyc < 2; cyc++) begin
            #1;
            for (int p = 0; p < NRD; p++) begin
                assertCount++;
                if (rdData[p*DW +: DW] !== 32'h0) begin
                    failCount++;
                    $display("[TB] FAIL r0_read cyc%0d port%0d: got %h expected 0", cyc, p, rdData[p*DW +: DW]);
                end
            end
            tick();
            wrEn = '0;
        end
    endtask

    task automatic test_bypass_all();
        idleInputs();
        setWrite(0, 1'b1, 5'd3, 32'hA5);
        for (int p = 0; p < NRD; p++) setRead(p, 5'd3);
        #1;
        for (int p = 0; p < NRD; p++) begin
            assertCount++;
            if (rdData[p*DW +: DW] !== 32'hA5) begin
                failCount++;
                $display("[TB] FAIL bypass_all port%0d: got %h expected 000000a5", p, rdData[p*DW +: DW]);
            end
        end
        tick();
        wrEn = '0;
    endtask

    task automatic test_random();
        logic [DW-1:0] exp;
        idleInputs();
        for (int cyc = 0; cyc < 300; cyc++) begin
            for (int w = 0; w < NWR; w++)
                setWrite(w, 1'($urandom_range(0, 1)), AW'($urandom_range(0, (cyc < 150) ? 7 : 31)), $urandom);
            for (int p = 0; p < NRD; p++) setRead(p, AW'($urandom_range(0, (cyc < 150) ? 7 : 31)));
            #1;
            for (int p = 0; p < NRD; p++) begin
                exp = modelRead(rdAddr[p*AW +: AW]);
                assertCount++;
                if (rdData[p*DW +: DW] !== exp) begin
                    failCount++;
                    $display("[TB] FAIL random cyc%0d port%0d r%0d: got %h expected %h",
                             cyc, p, rdAddr[p*AW +: AW], rdData[p*DW +: DW], exp);
                end
            end
            tick();
        end
        idleInputs();
    endtask

    task automatic test_mid_run_reset();
        idleInputs();
        setWrite(0, 1'b1, 5'd3, 32'hA5);
        tick();
        wrEn = '0;
        #2;
        aresetn    = 1'b0;
        refRun     = 1'b0;
        clearEdges = 0;
        #1;
        assertCount++;
        if (initDone !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL async_reset_init_done: got %b expected 0", initDone);
        end
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        for (int c = 0; c < 10; c++) tick();
        #2;
        aresetn    = 1'b0;
        clearEdges = 0;
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        for (int c = 1; c <= CLEAR_CYCLES; c++) begin
            tick();
            assertCount++;
            if (initDone !== (c == CLEAR_CYCLES)) begin
                failCount++;
                $display("[TB] FAIL rerun_init_done cycle %0d: got %b expected %b", c, initDone, c == CLEAR_CYCLES);
            end
        end
        setRead(0, 5'd3);
        #1;
        assertCount++;
        if (rdData[0 +: DW] !== 32'h0 || rdData[0 +: DW] !== modelRead(5'd3)) begin
            failCount++;
            $display("[TB] FAIL r3_after_reset: got %h expected 0", rdData[0 +: DW]);
        end
    endtask

`ifdef REGFILE_SCOREBOARD_EN
    task automatic test_scoreboard();
        idleInputs();
        setRead(0, 5'd9);
        setRead(1, 5'd0);
        issueEn[0]          = 1'b1;
        issueAddr[0 +: AW]  = 5'd9;
        #1;
        assertCount++;
        if (busy[0] !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL sb_before_issue: got %b expected 0", busy[0]);
        end
        tick();
        issueEn = '0;
        #1;
        assertCount++;
        if (busy[0] !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL sb_after_issue: got %b expected 1", busy[0]);
        end
        assertCount++;
        if (busy[1] !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL sb_r0: got %b expected 0", busy[1]);
        end
        setWrite(0, 1'b1, 5'd9, 32'h99);
        issueEn[1]          = 1'b1;
        issueAddr[AW +: AW] = 5'd9;
        #1;
        assertCount++;
        if (busy[0] !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL sb_write_mask: got %b expected 0", busy[0]);
        end
        tick();
        wrEn    = '0;
        issueEn = '0;
        #1;
        assertCount++;
        if (busy[0] !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL sb_set_over_clear: got %b expected 1", busy[0]);
        end
        flush               = 1'b1;
        issueEn[0]          = 1'b1;
        issueAddr[0 +: AW]  = 5'd9;
        tick();
        flush   = 1'b0;
        issueEn = '0;
        #1;
        assertCount++;
        if (busy[0] !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL sb_flush: got %b expected 0", busy[0]);
        end
    endtask
`endif

    initial begin
        $display("[TB] regfile_mp test start");
        test_reset();
        test_same_index_write();
        test_r0_write();
        test_bypass_all();
        test_random();
`ifdef REGFILE_SCOREBOARD_EN
        test_scoreboard();
`endif
        test_mid_run_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
